// File: rtl/result_queue_pkg.sv
// Shared widths, defaults and the result-entry layout for the result queue.
package result_queue_pkg;

    localparam int DEFAULT_DEPTH        = 64;
    localparam int DEFAULT_XW           = 10;
    localparam int DEFAULT_YW           = 10;
    localparam int DEFAULT_SW           = 8;
    localparam int DEFAULT_AFULL_MARGIN = 4;

    // Packed entry layout {last, scale, y, x}, shown at the default widths.
    typedef struct packed {
        logic                  last;
        logic [DEFAULT_SW-1:0] scale;
        logic [DEFAULT_YW-1:0] y;
        logic [DEFAULT_XW-1:0] x;
    } result_entry_t;

    localparam int RESULT_ENTRY_W = $bits(result_entry_t);

    function automatic int entry_width(input int xw, input int yw, input int sw);
        return xw + yw + sw + 1;
    endfunction

endpackage

// File: rtl/result_queue_ram.sv
// Simple dual-port storage for the result queue with a synchronous read port.
module result_queue_ram #(
    parameter int WORDS = 63,
    parameter int WIDTH = 29,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] fwd_data;
    logic             fwd;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rd_q <= mem[raddr];
    end

    // A same-edge write to the address being read returns the new word, kept outside the array.
    always_ff @(posedge clk) begin
        fwd      <= we && (waddr == raddr);
        fwd_data <= wdata;
    end

    assign rdata = fwd ? fwd_data : rd_q;

endmodule

// File: rtl/result_queue.sv
// Detection-result FIFO: DEPTH-1 RAM words plus a show-ahead output register.
module result_queue
    import result_queue_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int XW           = DEFAULT_XW,
    parameter int YW           = DEFAULT_YW,
    parameter int SW           = DEFAULT_SW,
    parameter int AFULL_MARGIN = DEFAULT_AFULL_MARGIN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [XW-1:0]          wr_x,
    input  logic [YW-1:0]          wr_y,
    input  logic [SW-1:0]          wr_scale,
    input  logic                   wr_last,
    output logic                   wr_full,
    output logic                   wr_afull,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [XW-1:0]          m_x,
    output logic [YW-1:0]          m_y,
    output logic [SW-1:0]          m_scale,
    output logic                   m_last,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int EW    = entry_width(XW, YW, SW);
    localparam int SLOTS = DEPTH - 1;

    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next, ram_count, ram_raddr;
    logic [EW-1:0] wr_entry, ram_rdata, out_entry;
    logic          pop, wr_accept, out_free, ram_empty, refill, bypass, ram_write, ram_we;

    function automatic logic [AW-1:0] next_slot(input logic [AW-1:0] p);
        return (p == AW'(SLOTS - 1)) ? '0 : p + AW'(1);
    endfunction

    assign wr_entry  = {wr_last, wr_scale, wr_y, wr_x};
    assign wr_full   = (count == CW'(DEPTH));
    assign wr_afull  = (CW'(DEPTH) - count) <= CW'(AFULL_MARGIN);
    assign pop       = m_valid && m_ready;
    assign wr_accept = wr_en && !wr_full;
    assign out_free  = !m_valid || pop;
    assign ram_empty = (ram_count == '0);
    assign refill    = out_free && !ram_empty;
    assign bypass    = out_free && ram_empty && wr_accept;
    assign ram_write = wr_accept && !bypass;

    // The RAM is read one edge ahead so the word at rd_ptr is ready whenever a refill is due.
    assign rd_ptr_next = refill ? next_slot(rd_ptr) : rd_ptr;
    assign ram_raddr   = reset ? '0 : rd_ptr_next;
    assign ram_we      = ram_write && !reset;

    result_queue_ram #(
        .WORDS (SLOTS),
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            count     <= '0;
            m_valid   <= 1'b0;
            out_entry <= '0;
            overflow  <= 1'b0;
        end else begin
            if (ram_write)
                wr_ptr <= next_slot(wr_ptr);
            rd_ptr <= rd_ptr_next;

            case ({ram_write, refill})
                2'b10:   ram_count <= ram_count + AW'(1);
                2'b01:   ram_count <= ram_count - AW'(1);
                default: ram_count <= ram_count;
            endcase

            case ({wr_accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (bypass) begin
                out_entry <= wr_entry;
                m_valid   <= 1'b1;
            end else if (refill) begin
                out_entry <= ram_rdata;
                m_valid   <= 1'b1;
            end else if (pop) begin
                m_valid   <= 1'b0;
            end

            if (wr_en && wr_full)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
        end
    end

    assign {m_last, m_scale, m_y, m_x} = out_entry;

endmodule

// File: tb/tb_result_queue.sv
// Directed plus randomized checks of result_queue against a queue-based reference model.
module tb_result_queue;
    import result_queue_pkg::*;

    localparam int DEPTH = DEFAULT_DEPTH;
    localparam int MARGIN = DEFAULT_AFULL_MARGIN;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  wr_en = 1'b0;
    logic [DEFAULT_XW-1:0] wr_x = '0;
    logic [DEFAULT_YW-1:0] wr_y = '0;
    logic [DEFAULT_SW-1:0] wr_scale = '0;
    logic                  wr_last = 1'b0;
    logic                  wr_full, wr_afull, m_valid;
    logic                  m_ready = 1'b0;
    logic [DEFAULT_XW-1:0] m_x;
    logic [DEFAULT_YW-1:0] m_y;
    logic [DEFAULT_SW-1:0] m_scale;
    logic                  m_last;
    logic [$clog2(DEPTH):0] count;
    logic                  overflow;
    logic                  clr_overflow = 1'b0;

    int            errors = 0;
    int            checks = 0;
    result_entry_t model_q[$];
    bit            model_ovf = 1'b0;

    result_queue dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_scale     (wr_scale),
        .wr_last      (wr_last),
        .wr_full      (wr_full),
        .wr_afull     (wr_afull),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_x          (m_x),
        .m_y          (m_y),
        .m_scale      (m_scale),
        .m_last       (m_last),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic result_entry_t rand_entry();
        result_entry_t e;
        e.x     = DEFAULT_XW'($urandom);
        e.y     = DEFAULT_YW'($urandom);
        e.scale = DEFAULT_SW'($urandom);
        e.last  = 1'($urandom);
        return e;
    endfunction

    task automatic apply_stimulus(input logic en, input result_entry_t e,
                                  input logic ready, input logic clr);
        wr_en        = en;
        wr_x         = e.x;
        wr_y         = e.y;
        wr_scale     = e.scale;
        wr_last      = e.last;
        m_ready      = ready;
        clr_overflow = clr;
    endtask

    task automatic check_output();
        result_entry_t head;
        check("m_valid", 32'(m_valid), 32'(model_q.size() != 0));
        check("count", 32'(count), 32'(model_q.size()));
        check("wr_full", 32'(wr_full), 32'(model_q.size() == DEPTH));
        check("wr_afull", 32'(wr_afull), 32'((DEPTH - model_q.size()) <= MARGIN));
        check("overflow", 32'(overflow), 32'(model_ovf));
        if (model_q.size() != 0) begin
            head = model_q[0];
            check("m_data", 32'({m_last, m_scale, m_y, m_x}), 32'(head));
        end
    endtask

    // The model holds every entry in one ordered queue; the head is what the host sees.
    task automatic model_update();
        bit full, popping, accept;
        if (reset) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            full    = (model_q.size() == DEPTH);
            popping = (model_q.size() != 0) && m_ready;
            accept  = wr_en && !full;
            if (wr_en && full)
                model_ovf = 1'b1;
            else if (clr_overflow)
                model_ovf = 1'b0;
            if (popping)
                void'(model_q.pop_front());
            if (accept)
                model_q.push_back(result_entry_t'({wr_last, wr_scale, wr_y, wr_x}));
        end
    endtask

    task automatic tick();
        check_output();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_to(input int n);
        for (int i = 0; i < 2 * DEPTH && model_q.size() < n; i++) begin
            apply_stimulus(1'b1, rand_entry(), 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain_to(input int n);
        for (int i = 0; i < 2 * DEPTH && model_q.size() > n; i++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
            tick();
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        result_entry_t e;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        check("m_data_after_reset", 32'({m_last, m_scale, m_y, m_x}), 32'd0);

        $display("[TB] single write");
        e = '{last: 1'b0, scale: 8'd2, y: 10'd7, x: 10'd5};
        apply_stimulus(1'b1, e, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("single_x", 32'(m_x), 32'd5);
        check("single_y", 32'(m_y), 32'd7);
        check("single_scale", 32'(m_scale), 32'd2);

        $display("[TB] fill and overflow");
        fill_to(DEPTH);
        apply_stimulus(1'b1, rand_entry(), 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("ovf_count", 32'(count), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);

        $display("[TB] full drain");
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) tick();
        check("drained_valid", 32'(m_valid), 32'd0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        tick();

        $display("[TB] steady write and pop at count 10");
        fill_to(10);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, rand_entry(), 1'b1, 1'b0);
            tick();
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("steady_count", 32'(count), 32'd10);

        $display("[TB] write rejected while full and popping");
        fill_to(DEPTH);
        apply_stimulus(1'b1, rand_entry(), 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("full_pop_count", 32'(count), 32'(DEPTH - 1));
        check("full_pop_ovf", 32'(overflow), 32'd1);
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("ovf_cleared", 32'(overflow), 32'd0);
        fill_to(DEPTH);
        apply_stimulus(1'b1, rand_entry(), 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("ovf_set_wins", 32'(overflow), 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 9) < 6), rand_entry(),
                           1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 19) == 0));
            tick();
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);

        $display("[TB] reset mid-drain");
        fill_to(36);
        drain_to(30);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        check("reset_valid", 32'(m_valid), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_data", 32'({m_last, m_scale, m_y, m_x}), 32'd0);
        e = '{last: 1'b1, scale: 8'd9, y: 10'd300, x: 10'd17};
        apply_stimulus(1'b1, e, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        tick();
        check("post_reset_last", 32'(m_last), 32'd1);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_queue.md
Name: result_queue

Overview:
- Responder for the result-queue write interface that the computation engine drives.
- Buffers detection results (window x, window y, scale index, end-of-frame flag) in an on-chip FIFO.
- Presents them to the host side as a registered valid/ready stream.
- Provides a full back-pressure signal, occupancy count and a sticky overflow flag for host status registers.

Parameters:
- DEPTH, 64, FIFO entries; power of two, ≥4
- XW, 10, window x width (matches pkg_imageCache::rowBits)
- YW, 10, window y width (matches pkg_imageCache::colBits)
- SW, 8, scale index width
- AFULL_MARGIN, 4, almost-full asserted when free entries ≤ margin

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request from result store
- wr_x  in  XW  window x
- wr_y  in  YW  window y
- wr_scale  in  SW  scale index
- wr_last  in  1  entry is end-of-frame marker
- wr_full  out  1  queue cannot accept a write this cycle
- wr_afull  out  1  almost full
- m_valid  out  1  output entry valid
- m_ready  in  1  host accepts output entry
- m_x  out  XW  output x
- m_y  out  YW  output y
- m_scale  out  SW  output scale
- m_last  out  1  output end-of-frame marker
- count  out  log2(DEPTH)+1  total entries held (RAM plus output register)
- overflow  out  1  sticky: write attempted while full
- clr_overflow  in  1  clears overflow

Behaviour:
- Reset (synchronous, active-high, takes priority over all other inputs):
  - m_valid=0, wr_full=0, wr_afull=0, count=0, overflow=0.
  - Pointers cleared; m_x/m_y/m_scale/m_last = 0.
  - Reset mid-stream discards all contents.
- Storage:
  - Entry = {last, scale, y, x}, width XW+YW+SW+1.
  - DEPTH-1 RAM entries plus one output register; total capacity = DEPTH.
  - RAM has a synchronous read.
- Write:
  - Accepted when wr_en && !wr_full; both count and pointer update on the same edge.
  - wr_full is driven combinationally from the registered count: wr_full = (count == DEPTH).
  - A write while full is dropped and sets overflow the next cycle.
  - A write is rejected when full even if m_ready pops in the same cycle; no same-cycle pass-through when full.
- Read (show-ahead):
  - Pop = m_valid && m_ready.
  - Output register refills from RAM whenever it is empty or being popped and the RAM is non-empty.
  - Bypass: when the RAM is empty and the output register is empty or popping, an accepted write loads the output register directly.
  - Latency: write at edge N gives m_valid=1 at N+1 (empty queue).
  - m_* stable while m_valid && !m_ready.
- Count:
  - +1 on accepted write, −1 on pop, unchanged when both occur.
  - Never exceeds DEPTH and never underflows.
  - wr_afull = (DEPTH − count ≤ AFULL_MARGIN).
- Overflow:
  - Set on wr_en && wr_full; cleared by clr_overflow.
  - Set wins if both occur in the same cycle.
- Pointers wrap modulo DEPTH-1 RAM slots; implemented with explicit compare, not binary wrap.
- wr_last entries are ordinary entries, with no special flow control; the host uses m_last to delimit frames.

Decomposition:
- struct_result_entry typedef and entry-width constant go in structs.
- DEPTH default goes in globalDefinitions.
- Natural sub-module: result_queue_ram (simple dual-port, one write port, one synchronous read port, DEPTH-1 words) so synthesis infers block RAM.
- Flow control stays in result_queue.

Test Plan:
- Reset then a single write {x=5, y=7, scale=2, last=0} with m_ready=0 → m_valid=1 next cycle, fields match, count=1, held stable 5 cycles.
- 64 back-to-back writes, m_ready=0 → count=64, wr_full=1, wr_afull=1 from count=60; a 65th write sets overflow, count stays 64.
- Drain the full queue with m_ready=1 continuously → 64 entries in write order, one per cycle, m_valid drops after the last, count=0.
- Simultaneous write and pop at count=10 for 20 cycles → count stays 10, order preserved.
- Full queue with wr_en=1 and m_ready=1 in the same cycle → pop happens, write rejected, overflow=1, count=63; clr_overflow then clears it.
- Reset asserted with count=30 mid-drain → next cycle m_valid=0, count=0; a subsequent write is delivered normally with m_last preserved.
